// File: rtl/ctr_sched_pkg.sv
// Shared definitions for the counter scheduler: FSM state encodings and
// default sizing constants.
package ctr_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam int DEF_N_REQ = 4;
  localparam int DEF_WIDTH = 8;

endpackage

// File: rtl/ctr_sched_rr_pick.sv
// Round-robin picker: returns the first asserted request at or above the
// pointer, wrapping past N_REQ-1 back to 0. Purely combinational.
module rr_pick #(
  parameter int N_REQ = 4,
  parameter int IW    = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IW-1:0]    ptr,
  output logic [N_REQ-1:0] pick,
  output logic [IW-1:0]    pick_idx,
  output logic             pick_any
);

  logic [IW:0]   sum;
  logic [IW-1:0] j;

  // Scan N_REQ positions starting at ptr; the first hit wins.
  always_comb begin
    pick     = '0;
    pick_idx = '0;
    pick_any = 1'b0;
    sum      = '0;
    j        = '0;
    for (int k = 0; k < N_REQ; k++) begin
      sum = {1'b0, ptr} + (IW+1)'(k);
      if (sum >= (IW+1)'(N_REQ)) sum = sum - (IW+1)'(N_REQ);
      j = sum[IW-1:0];
      if (!pick_any && req[j]) begin
        pick_any = 1'b1;
        pick[j]  = 1'b1;
        pick_idx = j;
      end
    end
  end

endmodule

// File: rtl/ctr_sched.sv
// Counter scheduler: round-robin shares one loadable up-counter among
// N_REQ requesters. Each granted interval runs LOAD -> RUN (len cycles)
// -> DONE. Optional owner abort is compiled in with CTR_SCHED_ABORT_EN.
// Handshake: req is a level held by the client until its done pulse (or,
// with abort enabled, dropped to cancel); grant is one-hot and held from
// LOAD through DONE; done is a single-cycle pulse during DONE.
module ctr_sched
  import ctr_sched_pkg::*;
#(
  parameter int N_REQ = DEF_N_REQ,
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*WIDTH-1:0] req_len,
  output logic [N_REQ-1:0]       grant,
  output logic [N_REQ-1:0]       done,
  output logic                   busy,
  output logic                   ctr_load,
  output logic [WIDTH-1:0]       ctr_load_value,
  output logic                   ctr_en,
  input  logic [WIDTH-1:0]       ctr_count
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  state_t           state;
  logic [IW-1:0]    owner;
  logic [IW-1:0]    rr_ptr;
  logic [IW-1:0]    next_ptr;
  logic [WIDTH-1:0] len;
  logic [WIDTH-1:0] len_m1;
  logic [WIDTH-1:0] pick_len;
  logic [N_REQ-1:0] pick;
  logic [IW-1:0]    pick_idx;
  logic             pick_any;
  logic             abort;

  rr_pick #(.N_REQ(N_REQ), .IW(IW)) u_pick (
    .req      (req),
    .ptr      (rr_ptr),
    .pick     (pick),
    .pick_idx (pick_idx),
    .pick_any (pick_any)
  );

`ifdef CTR_SCHED_ABORT_EN
  logic owner_req;
  assign owner_req = req[owner];
  assign abort     = !owner_req;
`else
  assign abort = 1'b0;
`endif

  assign len_m1         = len - WIDTH'(1);
  assign next_ptr       = (owner == IW'(N_REQ-1)) ? '0 : owner + IW'(1);
  assign ctr_load_value = '0;
  // Enable is decoded from state and the counter value only, never from req.
  assign ctr_en         = (state == ST_RUN) && (ctr_count != len_m1);

  // Select the winning requester's length slice (pick is one-hot).
  always_comb begin
    pick_len = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (pick[i]) pick_len = req_len[i*WIDTH +: WIDTH];
    end
  end

  // Scheduler FSM with registered grant/done/busy/load outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      owner    <= '0;
      rr_ptr   <= '0;
      len      <= '0;
      grant    <= '0;
      done     <= '0;
      busy     <= 1'b0;
      ctr_load <= 1'b0;
    end else begin
      done     <= '0;
      ctr_load <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (pick_any) begin
            owner    <= pick_idx;
            len      <= pick_len;
            grant    <= pick;
            busy     <= 1'b1;
            ctr_load <= 1'b1;
            state    <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          if (abort) begin
            grant  <= '0;
            busy   <= 1'b0;
            rr_ptr <= next_ptr;
            state  <= ST_IDLE;
          end else if (len != '0) begin
            state <= ST_RUN;
          end else begin
            done  <= grant;
            state <= ST_DONE;
          end
        end
        ST_RUN: begin
          if (abort) begin
            grant  <= '0;
            busy   <= 1'b0;
            rr_ptr <= next_ptr;
            state  <= ST_IDLE;
          end else if (ctr_count == len_m1) begin
            done  <= grant;
            state <= ST_DONE;
          end
        end
        ST_DONE: begin
          grant  <= '0;
          busy   <= 1'b0;
          rr_ptr <= next_ptr;
          state  <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/ctr_sched.md
Name: ctr_sched

Overview:
- Sequences the team's shared loadable up-counter (`counter`, ports load/load_value/en/count) among N_REQ requesters.
- Each requester asks for an interval of `req_len` clock cycles.
- The block round-robin arbitrates between requesters, loads and enables the counter, detects interval expiry, and pulses a per-requester done.
- Sits between client FSMs and a single `counter` instance; it never drives the counter's reset.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- WIDTH, 8, counter and length width; must match the counter's WIDTH.

Ports:
- clk  in  1  system clock, rising-edge.
- rst_n  in  1  asynchronous, active-low reset.
- req  in  N_REQ  level request per requester; held until done or abort.
- req_len  in  N_REQ*WIDTH  flattened lengths; slice i = [i*WIDTH +: WIDTH].
- grant  out  N_REQ  one-hot owner; held from LOAD through DONE.
- done  out  N_REQ  one-cycle pulse to the owner at interval end.
- busy  out  1  high in any state other than IDLE.
- ctr_load  out  1  drives counter.load.
- ctr_load_value  out  WIDTH  drives counter.load_value.
- ctr_en  out  1  drives counter.en.
- ctr_count  in  WIDTH  from counter.count.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; grant, done, busy, ctr_load, ctr_en = 0; ctr_load_value=0; rr pointer=0, so requester 0 has top priority.
- State IDLE:
  - If req!=0, pick the first asserted req scanning upward from the rr pointer, wrapping.
  - Latch owner id and len=req_len[id], then go to LOAD.
  - With no request, stay in IDLE.
- State LOAD:
  - ctr_load=1, ctr_load_value=0, ctr_en=0; grant[id]=1.
  - Next state is RUN if len!=0, else DONE (RUN skipped, counter never enabled).
- State RUN:
  - ctr_en=1 while ctr_count != len-1.
  - When ctr_count == len-1: ctr_en=0 that cycle and go to DONE.
  - Exactly len cycles are spent in RUN. len=1 gives one RUN cycle with ctr_en=0.
- State DONE:
  - done[id]=1 for one cycle; grant held.
  - rr pointer = (id+1) mod N_REQ; next state IDLE.
- Arbitration timing:
  - Minimum gap between back-to-back grants is one IDLE cycle.
  - req changes during DONE are sampled in the following IDLE.
- Arithmetic: comparison is in WIDTH bits. len-1 for len=0 is never evaluated (LOAD bypasses RUN).
- req_len changes after the latch in IDLE are ignored.
- ctr_count is trusted. If it overshoots (external counter reset), the scheduler stays in RUN until the count wraps to len-1.
- All outputs are registered or decoded from state only; no combinational path from req to ctr_*.

Optional Feature:
- Macro: CTR_SCHED_ABORT_EN.
- Defined:
  - Owner dropping req[id] in LOAD or RUN aborts the interval.
  - Next cycle: state=IDLE, ctr_en=0, grant=0, no done pulse; rr pointer advances as if done.
- Undefined:
  - req withdrawal after grant is ignored; the interval completes and done still pulses.

Decomposition:
- Shared package `ctr_sched_pkg`: state encodings ST_IDLE=2'd0, ST_LOAD=2'd1, ST_RUN=2'd2, ST_DONE=2'd3; default N_REQ/WIDTH constants.
- One sub-module `rr_pick`: combinational; inputs req and rr pointer; outputs one-hot pick and its index.

Test Plan:
- Single requester: req[0]=1, req_len[0]=42 after rst_n release.
  - grant[0] one cycle later; ctr_load=1 for one cycle.
  - ctr_count ramps 0..41; ctr_en low when count=41.
  - done[0] pulses on the next cycle; busy falls one cycle after.
- Round robin: req=4'b1111 held, all lengths 3.
  - Grants in order 0,1,2,3,0.
  - Each grant lasts 1+3+1=5 cycles with one IDLE gap between grants.
- Boundary lengths:
  - len=0: LOAD→DONE, ctr_en never asserted, done after 2 cycles.
  - len=1: one RUN cycle, count stays 0.
  - len=255: count reaches 254, no wrap.
- Reset mid-RUN: req[2], len=20; drop rst_n at count=7.
  - All outputs 0 immediately; no done[2].
  - After release, requester 0 wins over 2 if both are asserted.
- Abort, CTR_SCHED_ABORT_EN defined: req[1] with len=10, deassert at count=4.
  - IDLE next cycle, no done[1]; ctr_en low.
  - With the macro undefined, the run completes and done[1] pulses.
